// File: rtl/reg_bus_if.sv
// Register bus between a host decoder and one component target:
// single-cycle write strobe plus a read request with a one-cycle response.
interface reg_bus_if;
  logic        reg_wvalid;
  logic [15:0] reg_waddr;
  logic [31:0] reg_wdata;
  logic        reg_arvalid;
  logic [15:0] reg_araddr;
  logic        reg_rvalid;
  logic [31:0] reg_rdata;

  modport master (
    output reg_wvalid, reg_waddr, reg_wdata, reg_arvalid, reg_araddr,
    input  reg_rvalid, reg_rdata
  );

  modport slave (
    input  reg_wvalid, reg_waddr, reg_wdata, reg_arvalid, reg_araddr,
    output reg_rvalid, reg_rdata
  );
endinterface

// File: rtl/reg_bus_target.sv
// Component register target: control/config registers, event and busy
// statistics, and a debug log FIFO drained through a pop-on-read register.
module reg_bus_target #(
  parameter int unsigned COMP_ID       = 1,
  parameter int unsigned LOG_DBG_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  reg_bus_if.slave    bus,
  output logic        ctrl_enable,
  output logic [31:0] ctrl_cfg,
  input  logic        event_inc,
  input  logic        busy,
  input  logic        dbg_wvalid,
  input  logic [31:0] dbg_wdata
);

  localparam int unsigned DEPTH = 1 << LOG_DBG_DEPTH;
  localparam int unsigned CNT_W = LOG_DBG_DEPTH + 1;

  localparam logic [7:0] A_ENABLE  = 8'h00;
  localparam logic [7:0] A_CFG     = 8'h04;
  localparam logic [7:0] A_STATUS  = 8'h08;
  localparam logic [7:0] A_EVENTS  = 8'h10;
  localparam logic [7:0] A_BUSY    = 8'h14;
  localparam logic [7:0] A_CLEAR   = 8'h18;
  localparam logic [7:0] A_LOG_CNT = 8'h20;
  localparam logic [7:0] A_LOG_POP = 8'h24;
  localparam logic [7:0] A_LOG_DRP = 8'h28;
  localparam logic [7:0] A_ID      = 8'hFC;

  logic [31:0]              event_count;
  logic [31:0]              busy_cycles;
  logic [31:0]              log_dropped;
  logic [31:0]              log_mem [DEPTH];
  logic [LOG_DBG_DEPTH-1:0] wr_ptr;
  logic [LOG_DBG_DEPTH-1:0] rd_ptr;
  logic [CNT_W-1:0]         log_cnt;

  logic [7:0]  wr_addr_c;
  logic [7:0]  rd_addr_c;
  logic        log_empty_c;
  logic        log_full_c;
  logic        pop_c;
  logic        push_c;
  logic        drop_c;
  logic        clear_c;
  logic [31:0] rd_data_c;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{bus.reg_waddr[15:8], bus.reg_araddr[15:8]};

  // Decode and FIFO handshake; a pop frees a slot, so a push into a full log still lands
  always_comb begin
    wr_addr_c   = bus.reg_waddr[7:0];
    rd_addr_c   = bus.reg_araddr[7:0];
    log_empty_c = (log_cnt == '0);
    log_full_c  = (log_cnt == CNT_W'(DEPTH));
    pop_c       = bus.reg_arvalid && (rd_addr_c == A_LOG_POP) && !log_empty_c;
    push_c      = dbg_wvalid && (!log_full_c || pop_c);
    drop_c      = dbg_wvalid && log_full_c && !pop_c;
    clear_c     = bus.reg_wvalid && (wr_addr_c == A_CLEAR);
  end

  // Read mux sees pre-edge state, so a same-cycle write is not visible yet
  always_comb begin
    rd_data_c = '0;
    case (rd_addr_c)
      A_ENABLE:  rd_data_c = {31'b0, ctrl_enable};
      A_CFG:     rd_data_c = ctrl_cfg;
      A_STATUS:  rd_data_c = {28'b0, busy, log_full_c, log_empty_c, ctrl_enable};
      A_EVENTS:  rd_data_c = event_count;
      A_BUSY:    rd_data_c = busy_cycles;
      A_LOG_CNT: rd_data_c = 32'(log_cnt);
      A_LOG_POP: rd_data_c = log_empty_c ? 32'h0 : log_mem[rd_ptr];
      A_LOG_DRP: rd_data_c = log_dropped;
      A_ID:      rd_data_c = {16'hC4B0, 16'(COMP_ID)};
      default:   rd_data_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_c) log_mem[wr_ptr] <= dbg_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.reg_rvalid <= 1'b0;
      bus.reg_rdata  <= '0;
      ctrl_enable    <= 1'b0;
      ctrl_cfg       <= '0;
      event_count    <= '0;
      busy_cycles    <= '0;
      log_dropped    <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      log_cnt        <= '0;
    end else begin
      bus.reg_rvalid <= bus.reg_arvalid;
      if (bus.reg_arvalid) bus.reg_rdata <= rd_data_c;

      if (bus.reg_wvalid) begin
        case (wr_addr_c)
          A_ENABLE: ctrl_enable <= bus.reg_wdata[0];
          A_CFG:    ctrl_cfg    <= bus.reg_wdata;
          default:  ;
        endcase
      end

      // Statistics saturate; a clear overrides any same-cycle increment
      if (clear_c) begin
        event_count <= '0;
        busy_cycles <= '0;
        log_dropped <= '0;
      end else begin
        if (event_inc && ctrl_enable && (event_count != '1)) event_count <= event_count + 32'd1;
        if (busy && ctrl_enable && (busy_cycles != '1))      busy_cycles <= busy_cycles + 32'd1;
        if (drop_c && (log_dropped != '1))                   log_dropped <= log_dropped + 32'd1;
      end

      if (push_c) wr_ptr <= wr_ptr + LOG_DBG_DEPTH'(1);
      if (pop_c)  rd_ptr <= rd_ptr + LOG_DBG_DEPTH'(1);
      case ({push_c, pop_c})
        2'b10:   log_cnt <= log_cnt + CNT_W'(1);
        2'b01:   log_cnt <= log_cnt - CNT_W'(1);
        default: log_cnt <= log_cnt;
      endcase
    end
  end

endmodule
